// File: rtl/curve_point_unpacker.sv
// Receive side of the chunked point link: rebuilds {x,y} from CHUNK_W-bit beats, range checks it and,
// when CURVE_POINT_CHECK_EN is defined, verifies y^2 == x^3 + a*x + b (mod p) with a bit-serial multiplier.
module curve_point_unpacker #(
    parameter int P_WIDTH = 6,
    parameter int CHUNK_W = 2,
    parameter int P_MOD   = 37,
    parameter int A_COEF  = 0,
    parameter int B_COEF  = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHUNK_W-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*P_WIDTH-1:0] out_point,
    output logic                 out_on_curve,
    output logic                 out_is_inf,
    output logic                 out_frame_err
);
    localparam int PT_W   = 2 * P_WIDTH;
    localparam int N      = PT_W / CHUNK_W;
    localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(N - 1);
    localparam logic [P_WIDTH-1:0] P_VAL     = P_WIDTH'(P_MOD);

    if ((PT_W % CHUNK_W) != 0 || P_MOD >= (1 << P_WIDTH) || A_COEF >= P_MOD || B_COEF >= P_MOD) begin : g_bad_params
        $error("curve_point_unpacker: illegal parameter combination");
    end

    typedef struct packed {
        logic [P_WIDTH-1:0] x;
        logic [P_WIDTH-1:0] y;
    } curve_point_t;

`ifdef CURVE_POINT_CHECK_EN
    typedef enum logic [2:0] {RECV, MUL_YY, MUL_XX, MUL_XXX, MUL_AX, CMP, OUT} state_t;
`else
    typedef enum logic {RECV, OUT} state_t;
`endif

    state_t            state, state_next;
    curve_point_t      shreg, shreg_next;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_fire, at_last_beat, point_done, frame_ok, in_range, is_zero;

    assign beat_fire    = in_valid && in_ready;
    assign at_last_beat = (beat_cnt == LAST_BEAT);
    assign point_done   = beat_fire && (in_last || at_last_beat);
    assign frame_ok     = in_last && at_last_beat;
    // The first beat of a point starts from zero, so a short frame reports only its own chunks.
    assign shreg_next   = (beat_cnt == '0) ? curve_point_t'(PT_W'(in_data))
                                           : curve_point_t'((shreg << CHUNK_W) | PT_W'(in_data));
    assign in_range     = (shreg_next.x < P_VAL) && (shreg_next.y < P_VAL);
    assign is_zero      = (shreg_next == '0);

`ifdef CURVE_POINT_CHECK_EN
    localparam int MUL_W = (P_WIDTH > 1) ? $clog2(P_WIDTH) : 1;
    localparam int ACC_W = P_WIDTH + 2;
    localparam logic [MUL_W-1:0]   MUL_LAST = MUL_W'(P_WIDTH - 1);
    localparam logic [ACC_W-1:0]   P_EXT    = ACC_W'(P_MOD);
    localparam logic [ACC_W-1:0]   B_EXT    = ACC_W'(B_COEF);
    localparam logic [P_WIDTH-1:0] A_VAL    = P_WIDTH'(A_COEF);

    logic [MUL_W-1:0]   mul_cnt, bit_idx;
    logic [ACC_W-1:0]   acc, dbl, dbl_red, sum, acc_next, rhs_sum, rhs_red, rhs;
    logic [P_WIDTH-1:0] t0, t1, t2, mul_a, mul_b;
    logic               mul_bit, mul_done, mul_active, skip_check;

    assign skip_check = !frame_ok || is_zero || !in_range;
    assign mul_active = (state == MUL_YY) || (state == MUL_XX) || (state == MUL_XXX) || (state == MUL_AX);

    // mul_a supplies the multiplier bits (MSB first), mul_b is the addend.
    always_comb begin
        mul_a = '0;
        mul_b = shreg.x;
        case (state)
            MUL_YY: begin
                mul_a = shreg.y;
                mul_b = shreg.y;
            end
            MUL_XX:  mul_a = shreg.x;
            MUL_XXX: mul_a = t1;
            MUL_AX:  mul_a = A_VAL;
            default: ;
        endcase
    end

    assign bit_idx  = MUL_LAST - mul_cnt;
    assign mul_bit  = mul_a[bit_idx];
    assign mul_done = (mul_cnt == MUL_LAST);
    assign dbl      = acc << 1;
    assign dbl_red  = (dbl >= P_EXT) ? dbl - P_EXT : dbl;
    assign sum      = dbl_red + (mul_bit ? ACC_W'(mul_b) : '0);
    assign acc_next = (sum >= P_EXT) ? sum - P_EXT : sum;

    // t1 + t2 + b is below 3p, so two conditional subtractions fully reduce it.
    assign rhs_sum  = ACC_W'(t1) + ACC_W'(t2) + B_EXT;
    assign rhs_red  = (rhs_sum >= P_EXT) ? rhs_sum - P_EXT : rhs_sum;
    assign rhs      = (rhs_red >= P_EXT) ? rhs_red - P_EXT : rhs_red;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_cnt <= '0;
            acc     <= '0;
            t0      <= '0;
            t1      <= '0;
            t2      <= '0;
        end else if (mul_active) begin
            mul_cnt <= mul_done ? '0 : mul_cnt + 1'b1;
            acc     <= mul_done ? '0 : acc_next;
            if (mul_done) begin
                case (state)
                    MUL_YY:          t0 <= acc_next[P_WIDTH-1:0];
                    MUL_XX, MUL_XXX: t1 <= acc_next[P_WIDTH-1:0];
                    default:         t2 <= acc_next[P_WIDTH-1:0];
                endcase
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RECV;
        else       state <= state_next;
    end

    // NOTE: defaulting state_next first keeps this block purely combinational (no inferred latch).
    always_comb begin
        state_next = state;
        case (state)
            RECV: begin
                if (point_done) begin
`ifdef CURVE_POINT_CHECK_EN
                    state_next = skip_check ? OUT : MUL_YY;
`else
                    state_next = OUT;
`endif
                end
            end
`ifdef CURVE_POINT_CHECK_EN
            MUL_YY:  if (mul_done) state_next = MUL_XX;
            MUL_XX:  if (mul_done) state_next = MUL_XXX;
            MUL_XXX: if (mul_done) state_next = MUL_AX;
            MUL_AX:  if (mul_done) state_next = CMP;
            CMP:     state_next = OUT;
`endif
            OUT:     if (out_ready) state_next = RECV;
            default: state_next = RECV;
        endcase
    end

    always_comb begin
        in_ready  = (state == RECV);
        out_valid = (state == OUT);
    end

    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg         <= '0;
            beat_cnt      <= '0;
            out_point     <= '0;
            out_on_curve  <= 1'b0;
            out_is_inf    <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            if (beat_fire) begin
                shreg    <= shreg_next;
                beat_cnt <= point_done ? '0 : beat_cnt + 1'b1;
            end
            if (point_done) begin
                out_point     <= shreg_next;
                out_frame_err <= !frame_ok;
                out_is_inf    <= frame_ok && is_zero;
`ifdef CURVE_POINT_CHECK_EN
                out_on_curve  <= frame_ok && is_zero;
`else
                out_on_curve  <= frame_ok && in_range;
`endif
            end
`ifdef CURVE_POINT_CHECK_EN
            if (state == CMP) out_on_curve <= (ACC_W'(t0) == rhs);
`endif
            if (state == OUT && out_ready) begin
                out_on_curve  <= 1'b0;
                out_is_inf    <= 1'b0;
                out_frame_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_curve_point_unpacker.sv
// Randomized bench for curve_point_unpacker: an arithmetic model predicts every result and its latency.
module tb_curve_point_unpacker;
    localparam int P_WIDTH = 6;
    localparam int CHUNK_W = 2;
    localparam int P_MOD   = 37;
    localparam int A_COEF  = 0;
    localparam int B_COEF  = 7;
    localparam int PT_W    = 2 * P_WIDTH;
    localparam int N       = PT_W / CHUNK_W;
`ifdef CURVE_POINT_CHECK_EN
    localparam int FULL_LAT = 4 * P_WIDTH + 2;
    localparam bit CHECK_EN = 1'b1;
`else
    localparam int FULL_LAT = 1;
    localparam bit CHECK_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, in_ready, in_last;
    logic [CHUNK_W-1:0] in_data;
    logic               out_valid, out_ready;
    logic [PT_W-1:0]    out_point;
    logic               out_on_curve, out_is_inf, out_frame_err;

    always #5 clk = ~clk;

    curve_point_unpacker #(
        .P_WIDTH(P_WIDTH), .CHUNK_W(CHUNK_W), .P_MOD(P_MOD), .A_COEF(A_COEF), .B_COEF(B_COEF)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
        .out_on_curve(out_on_curve), .out_is_inf(out_is_inf), .out_frame_err(out_frame_err)
    );

    typedef struct {
        logic [PT_W-1:0] point;
        bit              on;
        bit              inf;
        bit              ferr;
        int              due;
    } exp_t;

    exp_t            exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    bit              stall = 1'b0;
    bit              pre_valid = 1'b0;
    logic [PT_W+2:0] held;
    logic [PT_W-1:0] last_point;
    bit              last_on, last_inf, last_ferr;
    exp_t            e;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit model_on_curve(input int x, input int y);
        return ((y * y) % P_MOD) == ((x * x * x + A_COEF * x + B_COEF) % P_MOD);
    endfunction

    // last_pos: index of the beat carrying in_last; N means in_last never appears.
    function automatic exp_t model_point(input int x, input int y, input int last_pos, input int acc_cyc);
        exp_t            r;
        logic [PT_W-1:0] word;
        word   = PT_W'((x << P_WIDTH) | y);
        r.inf  = 1'b0;
        r.on   = 1'b0;
        r.ferr = 1'b1;
        r.due  = acc_cyc + 1;
        r.point = word;
        if (last_pos < N - 1) begin
            r.point = word >> (PT_W - (last_pos + 1) * CHUNK_W);
        end else if (last_pos == N - 1) begin
            r.ferr = 1'b0;
            if (x == 0 && y == 0) begin
                r.inf = 1'b1;
                r.on  = 1'b1;
            end else if (x < P_MOD && y < P_MOD) begin
                r.on  = CHECK_EN ? model_on_curve(x, y) : 1'b1;
                r.due = acc_cyc + FULL_LAT;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Compare process: every result is matched against the model when out_valid rises, then held stable.
    always @(negedge clk) begin
        if (reset) begin
            pre_valid <= 1'b0;
        end else begin
            if (pre_valid && !out_valid) check("valid_dropped", 0, 1);
            if (out_valid) begin
                check("in_ready_low", in_ready, 0);
                if (!pre_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_point", out_point, e.point);
                        check("out_on_curve", out_on_curve, e.on);
                        check("out_is_inf", out_is_inf, e.inf);
                        check("out_frame_err", out_frame_err, e.ferr);
                        check("latency", cyc, e.due);
                        last_point <= out_point;
                        last_on    <= out_on_curve;
                        last_inf   <= out_is_inf;
                        last_ferr  <= out_frame_err;
                    end
                end else begin
                    check("hold_stable", {out_point, out_on_curve, out_is_inf, out_frame_err}, held);
                end
                held <= {out_point, out_on_curve, out_is_inf, out_frame_err};
            end
            pre_valid <= out_valid && !out_ready;
        end
    end

    // Called and returns just after a rising edge.
    task automatic send_point(input int x, input int y, input int last_pos);
        logic [PT_W-1:0] word;
        int              nb, gap, waited;
        bit              accepted;
        word = PT_W'((x << P_WIDTH) | y);
        nb   = (last_pos < N) ? last_pos + 1 : N;
        for (int b = 0; b < nb; b++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = word[PT_W-1-b*CHUNK_W -: CHUNK_W];
            in_last  = (b == last_pos);
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 200) begin
                @(negedge clk);
                if (in_ready) begin
                    accepted = 1'b1;
                    if (b == nb - 1) exp_q.push_back(model_point(x, y, last_pos, cyc));
                end
                waited++;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!accepted) begin
                check("in_ready_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_point"}, out_point, 0);
        check({tag, "_on_curve"}, out_on_curve, 0);
        check({tag, "_is_inf"}, out_is_inf, 0);
        check({tag, "_frame_err"}, out_frame_err, 0);
    endtask

    initial begin
        int x, y, mode, lp, waited;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        check("model_6_1", model_on_curve(6, 1), 1);
        check("model_6_2", model_on_curve(6, 2), 0);

        send_point(6, 1, N - 1);
        drain();
        check("base_point", last_point, 12'h181);
        check("base_on_curve", last_on, 1);

        send_point(6, 2, N - 1);
        drain();
        check("p6_2_on_curve", last_on, CHECK_EN ? 0 : 1);

        send_point(40, 1, N - 1);
        drain();
        check("x40_on_curve", last_on, 0);

        send_point(0, 0, N - 1);
        drain();
        check("inf_flag", last_inf, 1);
        check("inf_on_curve", last_on, 1);

        send_point(6, 1, 4);
        drain();
        check("early_last_ferr", last_ferr, 1);
        check("early_last_point", last_point, 12'h060);
        send_point(6, 1, N - 1);
        drain();
        check("after_ferr_clean", {last_ferr, last_on}, 2'b01);

        send_point(6, 1, N);
        drain();
        check("missing_last_ferr", last_ferr, 1);

        stall = 1'b1;
        send_point(6, 1, N - 1);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("stall_valid_seen", out_valid, 1);
        repeat (10) @(posedge clk);
        #1;
        check("stall_still_valid", out_valid, 1);
        stall = 1'b0;
        drain();

        stall = 1'b1;
        send_point(6, 1, N - 1);
        repeat (13) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_emit", out_valid, 0);
        send_point(6, 1, N - 1);
        drain();
        check("post_reset_point", last_point, 12'h181);
        check("post_reset_on", last_on, 1);

        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 9);
            x    = $urandom_range(0, 63);
            y    = $urandom_range(0, 63);
            lp   = N - 1;
            if (mode == 0) lp = $urandom_range(0, N - 2);
            else if (mode == 1) lp = N;
            else if (mode == 2) begin
                x = 0;
                y = 0;
            end else if (mode <= 5) begin
                x = $urandom_range(0, P_MOD - 1);
                for (int t = 0; t < P_MOD; t++) if (model_on_curve(x, t)) y = t;
            end
            send_point(x, y, lp);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
